// File: rtl/wifi_frame_tx.sv
// Serial framing transmitter: sends SYNC, command, data, XOR checksum as four
// back-to-back 8N1 bytes on a single UART line, with busy/done status.
module wifi_frame_tx #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = 8'hAA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_j1,
   input  logic [7:0] comando,
   input  logic [7:0] datos,
   output logic       tx,
   output logic       bussy,
   output logic       done
);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [1:0]    byte_idx, byte_idx_n;
   logic [7:0]    cmd_q, cmd_n, dat_q, dat_n;
   logic          tx_n, done_n, start_q;
   logic [7:0]    cur_byte;
   logic [2:0]    nxt_bit;
   logic          bit_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         cmd_q    <= '0;
         dat_q    <= '0;
         tx       <= 1'b1;
         bussy    <= 1'b0;
         done     <= 1'b0;
         start_q  <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         byte_idx <= byte_idx_n;
         cmd_q    <= cmd_n;
         dat_q    <= dat_n;
         tx       <= tx_n;
         bussy    <= (state_n != IDLE);
         done     <= done_n;
         start_q  <= start_j1;
      end
   end

   always_comb begin
      unique case (byte_idx)
         2'd0:    cur_byte = SYNC_BYTE;
         2'd1:    cur_byte = cmd_q;
         2'd2:    cur_byte = dat_q;
         default: cur_byte = SYNC_BYTE ^ cmd_q ^ dat_q;
      endcase
   end

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign nxt_bit = bit_idx + 3'd1;

   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      cmd_n      = cmd_q;
      dat_n      = dat_q;
      tx_n       = tx;
      done_n     = 1'b0;
      unique case (state)
         IDLE: begin
            baud_cnt_n = '0;
            bit_idx_n  = '0;
            byte_idx_n = '0;
            tx_n       = 1'b1;
            // Only a fresh rising edge seen while idle starts a frame.
            if (start_j1 && !start_q) begin
               state_n = START;
               cmd_n   = comando;
               dat_n   = datos;
               tx_n    = 1'b0;
            end
         end
         START: begin
            baud_cnt_n = baud_cnt + 1'b1;
            if (bit_end) begin
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               state_n    = DATA;
               tx_n       = cur_byte[0];
            end
         end
         DATA: begin
            baud_cnt_n = baud_cnt + 1'b1;
            if (bit_end) begin
               baud_cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = nxt_bit;
                  tx_n      = cur_byte[nxt_bit];
               end
            end
         end
         STOP: begin
            baud_cnt_n = baud_cnt + 1'b1;
            if (bit_end) begin
               baud_cnt_n = '0;
               if (byte_idx == 2'd3) begin
                  state_n    = IDLE;
                  byte_idx_n = '0;
                  done_n     = 1'b1;
               end else begin
                  byte_idx_n = byte_idx + 2'd1;
                  state_n    = START;
                  tx_n       = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_wifi_frame_tx.sv
// Bench for wifi_frame_tx: expected line waveform built from the frame rules
// (sync, cmd, data, xor; 8N1 LSB first) and compared sample by sample.
module tb_wifi_frame_tx;
   localparam int C  = 4;
   localparam int FL = 40 * C;
   localparam int NC = FL + 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_j1;
   logic [7:0] comando, datos;
   logic       tx, bussy, done;

   int n_cmp = 0;
   int n_err = 0;

   logic txs [NC];
   logic bus [NC];
   logic dns [NC];

   wifi_frame_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hAA)) dut (
      .clk(clk), .rst(rst), .start_j1(start_j1), .comando(comando),
      .datos(datos), .tx(tx), .bussy(bussy), .done(done)
   );

   always #5 clk = ~clk;

   // act: 0 none, 1 datos<=FF at act_cyc, 2 start toggles, 3 reset at act_cyc
   task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat,
                            input int act, input int act_cyc, input string nm);
      logic [7:0] bytes [4];
      logic       bits [40];
      int         wave_err, bhi, dcnt, didx;
      logic [7:0] got;
      bytes[0] = 8'hAA; bytes[1] = cmd; bytes[2] = dat;
      bytes[3] = 8'hAA ^ cmd ^ dat;
      for (int b = 0; b < 4; b++) begin
         bits[b*10] = 1'b0;
         for (int i = 0; i < 8; i++) bits[b*10+1+i] = bytes[b][i];
         bits[b*10+9] = 1'b1;
      end
      comando = cmd; datos = dat; start_j1 = 1'b0;
      @(negedge clk);
      start_j1 = 1'b1;
      for (int k = 0; k < NC; k++) begin
         @(negedge clk);
         txs[k] = tx; bus[k] = bussy; dns[k] = done;
         if (act == 1 && k == act_cyc) datos = 8'hFF;
         if (act == 2) begin
            if (k == 30 || k == 50) start_j1 = 1'b0;
            if (k == 40 || k == 60) start_j1 = 1'b1;
         end
         if (act == 3 && k == act_cyc) begin
            rst = 1'b1;
            #1;
            n_cmp++;
            if (tx !== 1'b1 || bussy !== 1'b0 || txs[k] !== 1'b0) begin
               n_err++;
               $display("FAIL %s async_reset: tx=%b bussy=%b pre_tx=%b, want 1 0 0",
                        nm, tx, bussy, txs[k]);
            end
            @(negedge clk);
            rst = 1'b0;
            return;
         end
      end
      n_cmp++;
      if (txs[0] !== 1'b0 || bus[0] !== 1'b1) begin
         n_err++;
         $display("FAIL %s first_cycle: tx=%b bussy=%b, want 0 1", nm, txs[0], bus[0]);
      end
      wave_err = 0; bhi = 0; dcnt = 0; didx = -1;
      for (int k = 0; k < NC; k++) begin
         if (k < FL && txs[k] !== bits[k/C]) wave_err++;
         if (k >= FL && txs[k] !== 1'b1) wave_err++;
         if (bus[k] === 1'b1) bhi++;
         if (dns[k] === 1'b1) begin dcnt++; didx = k; end
      end
      n_cmp++;
      if (wave_err != 0) begin
         n_err++;
         $display("FAIL %s waveform: %0d bad samples, want 0", nm, wave_err);
      end
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) got[i] = txs[(b*10+1+i)*C + C/2];
         n_cmp++;
         if (got !== bytes[b]) begin
            n_err++;
            $display("FAIL %s byte%0d: got %h, want %h", nm, b, got, bytes[b]);
         end
      end
      n_cmp++;
      if (bhi != FL) begin
         n_err++;
         $display("FAIL %s bussy_len: got %0d, want %0d", nm, bhi, FL);
      end
      n_cmp++;
      if (dcnt != 1 || didx != FL) begin
         n_err++;
         $display("FAIL %s done: count %0d at %0d, want 1 at %0d", nm, dcnt, didx, FL);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      rst = 1'b1; start_j1 = 1'b1; comando = 8'h00; datos = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || bussy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_values: tx=%b bussy=%b done=%b, want 1 0 0", tx, bussy, done);
      end
      rst = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || bussy !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL held_start_no_fire: %0d active cycles, want 0", bad);
      end
   endtask

   task automatic test_basic();
      run_frame(8'h12, 8'h34, 0, 0, "basic");
   endtask

   task automatic test_input_change();
      run_frame(8'h12, 8'h34, 1, 20, "datos_change");
   endtask

   task automatic test_retrigger();
      int bad = 0;
      run_frame(8'h5A, 8'hC3, 2, 0, "retrigger");
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bussy !== 1'b0 || tx !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL retrigger_single: %0d extra active cycles, want 0", bad);
      end
      run_frame(8'h3C, 8'h81, 0, 0, "retrigger_second");
   endtask

   task automatic test_mid_reset();
      run_frame(8'h12, 8'h34, 3, 70, "mid_reset");
      repeat (2) @(negedge clk);
      run_frame(8'h12, 8'h34, 0, 0, "after_reset");
   endtask

   task automatic test_checksum_edges();
      run_frame(8'h00, 8'h00, 0, 0, "cks_aa");
      run_frame(8'hAA, 8'h00, 0, 0, "cks_00");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         run_frame(8'($urandom), 8'($urandom), 0, 0, "random");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      run_frame(8'hF0, 8'h0F, 0, 0, "b2b_a");
      run_frame(8'h01, 8'h80, 0, 0, "b2b_b");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_input_change();
      test_retrigger();
      test_mid_reset();
      test_checksum_edges();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/wifi_frame_tx.md
# wifi_frame_tx

Serial framing transmitter for the WiFi link on the J1 SoC. It takes the command and data bytes that the CPU writes into the communications peripheral, plus that peripheral's start flag. It emits a 4-byte frame on a single 8N1 UART line: sync, command, data, checksum. It reports `bussy` back to the peripheral's read mux.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `SYNC_BYTE`, default 8'hAA: first byte of every frame.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_j1`  in  1  start flag from the peripheral register (level; CPU-held).
- `comando`  in  8  command byte.
- `datos`  in  8  data byte.
- `tx`  out  1  UART line, idle high.
- `bussy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Trigger: rising edge of `start_j1`, detected with a registered copy `start_q`. `start_q` resets to 1, so a flag held high through reset never fires. Firmware must write 0 and then 1 to send again.
- An edge is accepted only when the FSM is in IDLE in that cycle. Edges seen in any other state are discarded, not queued.
- On accept, `comando` and `datos` are latched in the same cycle. Later input changes do not affect the frame in flight.
- Frame byte order:
  - byte 0 = `SYNC_BYTE`
  - byte 1 = comando
  - byte 2 = datos
  - byte 3 = `SYNC_BYTE ^ comando ^ datos`, 8-bit XOR of the latched values.
- Each byte is sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). Bytes go back-to-back with no idle gap.
- FSM states:
  - IDLE → START on accepted edge.
  - START → DATA after one bit time.
  - DATA → STOP after bit index 7 completes.
  - STOP → START if the byte index is < 3 (index increments).
  - STOP → IDLE if the byte index is 3; `done` pulses on this transition.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps at the end of every bit.
  - Bit index runs 0..7.
  - Byte index runs 0..3 and returns to 0 in IDLE.
- `bussy` = (state != IDLE), registered.
- `tx` is driven from a register, never combinationally.

## Timing
- Reset values: `tx`=1, `bussy`=0, `done`=0, state=IDLE, all counters 0, `start_q`=1. Reset asserted mid-frame returns `tx` to 1 and `bussy` to 0 immediately (asynchronously); the frame is abandoned.
- Edge sampled at rising edge N (`start_j1`=1, `start_q`=0, IDLE): `bussy`=1 and `tx`=0 from edge N+1.
- Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- One byte lasts 10·CLKS_PER_BIT cycles; the frame lasts 40·CLKS_PER_BIT cycles.
- Timing at the end of the frame:
  - The last stop bit ends at edge N+1+40·CLKS_PER_BIT. At that edge `bussy` falls, `done`=1 for one cycle, and `tx` stays 1.
  - An edge sampled in that same cycle is rejected, because the state is not yet IDLE.
  - The earliest new frame starts `tx`=0 at N+3+40·CLKS_PER_BIT, provided `start_j1` was low for at least one prior sample.

## Test plan
1. Reset with `start_j1`=1 held, then release → `tx` stays 1 and `bussy` stays 0 for ≥ 100 cycles.
2. CLKS_PER_BIT=4, comando=8'h12, datos=8'h34, pulse `start_j1` 0→1 → decoded bytes AA, 12, 34, 8C. `bussy` is high for exactly 160 cycles. `done` pulses once, at the cycle `bussy` falls.
3. Same frame with `datos` changed to 8'hFF at cycle 20 → bytes unchanged (AA, 12, 34, 8C).
4. Toggle `start_j1` 0→1→0→1 during a frame → exactly one frame is sent. A fresh 0→1 after `bussy` falls sends a second frame.
5. Assert `rst` at cycle 70 of a frame → `tx`=1 and `bussy`=0 in the same cycle. A fresh 0→1 after release sends a complete, correct frame.
6. comando=8'h00, datos=8'h00 → checksum byte = 8'hAA. comando=8'hAA, datos=8'h00 → checksum = 8'h00.
